// File: rtl/cycle_sequencer.sv
// Opcode register, machine-cycle counter and interrupt/reset pending flags for the 6502 decoder.
// Registered outputs, 1-clock latency; scyc stalls inst/cycle. Define NMI_EDGE_EN for edge-triggered NMI.
module cycle_sequencer #(
    parameter logic [7:0] INT_OP  = 8'h00,
    parameter logic [2:0] RST_CYC = 3'd0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] dbus,
    input  logic       icyc,
    input  logic       rcyc,
    input  logic       scyc,
    input  logic       sinst,
    input  logic       nmi_in,
    input  logic       irq_in,
    input  logic       irqdis,
    output logic [7:0] inst,
    output logic [2:0] cycle,
    output logic       rstp,
    output logic       nmip,
    output logic       irqp,
    output logic       cycovf
);

    logic nmi_det;
    logic sinst_ok;
    logic int_take;
    logic icyc_eff;

`ifdef NMI_EDGE_EN
    logic nmi_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            nmi_q <= 1'b0;
        end else begin
            nmi_q <= nmi_in;
        end
    end

    assign nmi_det = nmi_in & ~nmi_q;
`else
    assign nmi_det = nmi_in;
`endif

    always_comb begin
        sinst_ok = 1'b0;
        int_take = 1'b0;
        icyc_eff = 1'b0;
        // The acknowledge only counts at the first cycle of the interrupt sequence.
        sinst_ok = sinst && (inst == INT_OP) && (cycle == 3'd0);
        int_take = rstp | nmip | (irqp & ~irqdis);
        icyc_eff = icyc & ~scyc & ~rcyc;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            inst   <= INT_OP;
            cycle  <= RST_CYC;
            rstp   <= 1'b1;
            nmip   <= 1'b0;
            irqp   <= 1'b0;
            cycovf <= 1'b0;
        end else begin
            irqp <= irq_in & ~irqdis;

            if (scyc) begin
                inst  <= inst;
                cycle <= cycle;
            end else if (rcyc) begin
                cycle <= RST_CYC;
                inst  <= int_take ? INT_OP : dbus;
            end else if (icyc) begin
                if (cycle != 3'd7) begin
                    cycle <= cycle + 3'd1;
                end
            end

            if (icyc_eff && (cycle == 3'd7)) begin
                cycovf <= 1'b1;
            end

            if (sinst_ok && rstp) begin
                rstp <= 1'b0;
            end

            // A fresh NMI wins over a same-cycle acknowledge.
            if (nmi_det) begin
                nmip <= 1'b1;
            end else if (sinst_ok && !rstp && nmip) begin
                nmip <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed vector bench for cycle_sequencer; NMI expectations follow NMI_EDGE_EN.
module tb_cycle_sequencer;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] dbus;
    logic       icyc, rcyc, scyc, sinst, nmi_in, irq_in, irqdis;
    logic [7:0] inst;
    logic [2:0] cycle;
    logic       rstp, nmip, irqp, cycovf;

    int n_vec = 0;
    int n_bad = 0;

`ifdef NMI_EDGE_EN
    localparam logic NH = 1'b0;
`else
    localparam logic NH = 1'b1;
`endif

    typedef struct {
        logic [7:0] dbus;
        logic       icyc, rcyc, scyc, sinst, nmi, irq, irqdis;
        logic [7:0] e_inst;
        logic [2:0] e_cycle;
        logic       e_rstp, e_nmip, e_irqp, e_ovf;
    } vec_t;

    vec_t tbl[32];

    cycle_sequencer dut (
        .clk(clk), .clr(clr), .dbus(dbus), .icyc(icyc), .rcyc(rcyc), .scyc(scyc),
        .sinst(sinst), .nmi_in(nmi_in), .irq_in(irq_in), .irqdis(irqdis),
        .inst(inst), .cycle(cycle), .rstp(rstp), .nmip(nmip), .irqp(irqp), .cycovf(cycovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] ei, input logic [2:0] ec,
                         input logic er, input logic en, input logic eq, input logic eo);
        logic [13:0] act, exp;
        act = {inst, cycle, rstp, nmip, irqp, cycovf};
        exp = {ei, ec, er, en, eq, eo};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got inst=%h cycle=%0d rstp=%b nmip=%b irqp=%b cycovf=%b, want inst=%h cycle=%0d rstp=%b nmip=%b irqp=%b cycovf=%b",
                     name, inst, cycle, rstp, nmip, irqp, cycovf, ei, ec, er, en, eq, eo);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic ic, input logic rc, input logic sc,
                         input logic si, input logic nm, input logic iq, input logic id);
        dbus = d; icyc = ic; rcyc = rc; scyc = sc; sinst = si;
        nmi_in = nm; irq_in = iq; irqdis = id;
    endtask

    task automatic idle();
        drive(8'hea, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic ic, input logic rc, input logic sc,
                                input logic si, input logic nm, input logic iq, input logic id,
                                input logic [7:0] ei, input logic [2:0] ec, input logic er,
                                input logic en, input logic eq, input logic eo);
        vec_t v;
        v.dbus = d; v.icyc = ic; v.rcyc = rc; v.scyc = sc; v.sinst = si;
        v.nmi = nm; v.irq = iq; v.irqdis = id;
        v.e_inst = ei; v.e_cycle = ec; v.e_rstp = er; v.e_nmip = en; v.e_irqp = eq; v.e_ovf = eo;
        return v;
    endfunction

    initial begin
        //            dbus   ic rc sc si nm iq id   inst   cyc rstp nmip irqp ovf
        tbl[0]  = mk(8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[1]  = mk(8'h69, 0, 1, 0, 0, 0, 0, 0, 8'h69, 0, 0, 0, 0, 0);
        tbl[2]  = mk(8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h69, 1, 0, 0, 0, 0);
        tbl[3]  = mk(8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h69, 2, 0, 0, 0, 0);
        tbl[4]  = mk(8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h69, 3, 0, 0, 0, 0);
        tbl[5]  = mk(8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h69, 3, 0, 0, 0, 0);
        tbl[6]  = mk(8'h00, 0, 0, 0, 0, 0, 1, 1, 8'h69, 3, 0, 0, 0, 0);
        tbl[7]  = mk(8'h18, 0, 1, 0, 0, 0, 1, 1, 8'h18, 0, 0, 0, 0, 0);
        tbl[8]  = mk(8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h18, 0, 0, 0, 1, 0);
        tbl[9]  = mk(8'h18, 0, 1, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 1, 0);
        tbl[10] = mk(8'h00, 0, 0, 0, 1, 0, 1, 0, 8'h00, 0, 0, 0, 1, 0);
        tbl[11] = mk(8'h69, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[12] = mk(8'hea, 0, 1, 0, 0, 0, 0, 0, 8'hea, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++)
            tbl[13+i] = mk(8'h00, 1, 0, 0, 0, 0, 0, 0, 8'hea, 3'(i + 1), 0, 0, 0, 0);
        tbl[20] = mk(8'h00, 1, 0, 0, 0, 0, 0, 0, 8'hea, 7, 0, 0, 0, 1);
        tbl[21] = mk(8'hd8, 1, 1, 0, 0, 0, 0, 0, 8'hd8, 0, 0, 0, 0, 1);
        tbl[22] = mk(8'h4c, 1, 1, 0, 0, 0, 0, 0, 8'h4c, 0, 0, 0, 0, 1);
        tbl[23] = mk(8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h4c, 0, 0, 1, 1, 1);
        tbl[24] = mk(8'h69, 0, 1, 0, 0, 1, 1, 0, 8'h00, 0, 0, 1, 1, 1);
        tbl[25] = mk(8'h00, 0, 0, 0, 1, 1, 1, 0, 8'h00, 0, 0, NH, 1, 1);
        tbl[26] = mk(8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, NH, 1, 1);
        tbl[27] = mk(8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, NH, 1, 1);
        tbl[28] = mk(8'h00, 0, 0, 0, 1, 0, 1, 0, 8'h00, 0, 0, 0, 1, 1);
        tbl[29] = mk(8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 1, 1, 1);
        tbl[30] = mk(8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 1, 1);
        tbl[31] = mk(8'h00, 0, 0, 0, 1, 1, 1, 0, 8'h00, 0, 0, 1, 1, 1);

        idle();
        clr = 1'b1;
        #12;
        check("reset_state", 8'h00, 0, 1, 0, 0, 0);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 32; i++) begin
            drive(tbl[i].dbus, tbl[i].icyc, tbl[i].rcyc, tbl[i].scyc, tbl[i].sinst,
                  tbl[i].nmi, tbl[i].irq, tbl[i].irqdis);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tbl[i].e_inst, tbl[i].e_cycle, tbl[i].e_rstp,
                  tbl[i].e_nmip, tbl[i].e_irqp, tbl[i].e_ovf);
            @(negedge clk);
        end

        // Count to 5, then clear asynchronously between edges.
        idle();
        icyc = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("count_to_5", 8'h00, 5, 0, 1, 0, 1);
        @(negedge clk);
        idle();
        #2;
        clr = 1'b1;
        #1;
        check("async_clr", 8'h00, 0, 1, 0, 0, 0);
        @(negedge clk);
        clr = 1'b0;
        sinst = 1'b1;
        @(posedge clk);
        #1;
        check("sinst_clears_rstp", 8'h00, 0, 0, 0, 0, 0);
        @(negedge clk);
        idle();
        @(posedge clk);
        #1;
        check("idle_after_reset", 8'h00, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
